// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, mux select
// codes, ALU operations, condition codes and the per-state Moore output decode.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } stateT;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef struct packed {
    logic       irWrite;
    logic       adrSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       nextPC;
    logic       regW;
    logic       memW;
    logic       aluOp;
    logic       branch;
  } mooreT;

  function automatic mooreT mooreOut(stateT s);
    mooreT m;
    m = '0;
    case (s)
      FETCH: begin
        m.aluSrcA   = 1'b1;
        m.aluSrcB   = SRCB_FOUR;
        m.resultSrc = RES_ALURESULT;
        m.irWrite   = 1'b1;
        m.nextPC    = 1'b1;
      end
      DECODE: begin
        m.aluSrcA   = 1'b1;
        m.aluSrcB   = SRCB_FOUR;
        m.resultSrc = RES_ALURESULT;
      end
      MEMADR:   m.aluSrcB = SRCB_IMM;
      MEMREAD:  m.adrSrc  = 1'b1;
      MEMWB: begin
        m.resultSrc = RES_DATA;
        m.regW      = 1'b1;
      end
      MEMWRITE: begin
        m.adrSrc = 1'b1;
        m.memW   = 1'b1;
      end
      EXECUTER: begin
        m.aluSrcB = SRCB_REG;
        m.aluOp   = 1'b1;
      end
      EXECUTEI: begin
        m.aluSrcB = SRCB_IMM;
        m.aluOp   = 1'b1;
      end
      ALUWB: begin
        m.resultSrc = RES_ALUOUT;
        m.regW      = 1'b1;
      end
      BRANCH: begin
        m.aluSrcB   = SRCB_IMM;
        m.resultSrc = RES_ALURESULT;
        m.branch    = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// enables and mux selects out. The controller is the master.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       IRWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       RegWrite;
  logic       PCWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output IRWrite, AdrSrc, MemWrite, RegWrite, PCWrite, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  IRWrite, AdrSrc, MemWrite, RegWrite, PCWrite, ALUSrcA,
           ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc
  );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, ARM condition evaluation and gating of the
// architectural write enables by the condition captured in DECODE.
module cond_logic
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluFlags,
  input  logic [1:0] flagW,
  input  logic       captureCond,
  input  logic       nextPC,
  input  logic       pcs,
  input  logic       regW,
  input  logic       noWrite,
  input  logic       memW,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWrite
);

  logic [3:0] flags;
  logic       condEx;
  logic       condExR;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  // NOTE: combinational blocks give every output a value on every path, so no latch is inferred.
  always_comb begin
    condEx = 1'b0;
    case (cond)
      COND_EQ: condEx = z;
      COND_NE: condEx = ~z;
      COND_CS: condEx = c;
      COND_CC: condEx = ~c;
      COND_MI: condEx = n;
      COND_PL: condEx = ~n;
      COND_VS: condEx = v;
      COND_VC: condEx = ~v;
      COND_HI: condEx = c & ~z;
      COND_LS: condEx = ~c | z;
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = ~z & (n == v);
      COND_LE: condEx = z | (n != v);
      COND_AL: condEx = 1'b1;
      COND_NV: condEx = 1'b0;
      default: condEx = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags   <= FLAG_RST;
      condExR <= 1'b0;
    end else begin
      if (captureCond) condExR <= condEx;
      if (flagW[1] & condExR) flags[3:2] <= aluFlags[3:2];
      if (flagW[0] & condExR) flags[1:0] <= aluFlags[1:0];
    end
  end

  // Writes are suppressed for the whole reset pulse, even mid-instruction.
  assign pcWrite  = ~reset & (nextPC | (pcs & condExR));
  assign regWrite = ~reset & regW & ~noWrite & condExR;
  assign memWrite = ~reset & memW & condExR;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM with registered outputs,
// ALU decode, and condition/flag handling in cond_logic.
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                           clk,
  input  logic                           reset,
  multicycle_controller_if.master        bus
);

  stateT      state;
  mooreT      mo;
  logic [1:0] cmdCtl;
  logic       cmdKnown;
  logic       cmdArith;
  logic       cmdNoWrite;
  logic       noWrite;
  logic [1:0] flagW;
  logic       pcs;

  function automatic stateT nextState(stateT s, logic [1:0] op, logic [5:0] funct);
    case (s)
      FETCH: return DECODE;
      DECODE: begin
        case (op)
          2'b00:   return funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   return MEMADR;
          2'b10:   return BRANCH;
          default: return FETCH;
        endcase
      end
      MEMADR:             return funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            return MEMWB;
      EXECUTER, EXECUTEI: return ALUWB;
      default:            return FETCH;
    endcase
  endfunction

  // Outputs are registered alongside the state by decoding the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      mo    <= mooreOut(FETCH);
    end else begin
      state <= nextState(state, bus.Op, bus.Funct);
      mo    <= mooreOut(nextState(state, bus.Op, bus.Funct));
    end
  end

  always_comb begin
    cmdCtl     = ALU_ADD;
    cmdKnown   = 1'b1;
    cmdArith   = 1'b0;
    cmdNoWrite = 1'b0;
    case (bus.Funct[4:1])
      4'b0100: begin cmdCtl = ALU_ADD; cmdArith = 1'b1; end
      4'b0010: begin cmdCtl = ALU_SUB; cmdArith = 1'b1; end
      4'b0000: cmdCtl = ALU_AND;
      4'b1100: cmdCtl = ALU_ORR;
      4'b1010: begin cmdCtl = ALU_SUB; cmdArith = 1'b1; cmdNoWrite = 1'b1; end
      default: begin cmdKnown = 1'b0; cmdNoWrite = 1'b1; end
    endcase
  end

  // NoWrite must still hold in ALUWB, where ALUOp is already low.
  assign noWrite = (bus.Op == 2'b00) & cmdNoWrite;
  assign flagW   = {mo.aluOp & cmdKnown & bus.Funct[0],
                    mo.aluOp & cmdArith & bus.Funct[0]};
  assign pcs     = mo.branch | (mo.regW & (bus.Rd == 4'd15));

  cond_logic #(
    .FLAG_RST (FLAG_RST)
  ) uCondLogic (
    .clk         (clk),
    .reset       (reset),
    .cond        (bus.Cond),
    .aluFlags    (bus.ALUFlags),
    .flagW       (flagW),
    .captureCond (state == DECODE),
    .nextPC      (mo.nextPC),
    .pcs         (pcs),
    .regW        (mo.regW),
    .noWrite     (noWrite),
    .memW        (mo.memW),
    .pcWrite     (bus.PCWrite),
    .regWrite    (bus.RegWrite),
    .memWrite    (bus.MemWrite)
  );

  assign bus.IRWrite    = mo.irWrite & ~reset;
  assign bus.AdrSrc     = mo.adrSrc;
  assign bus.ALUSrcA    = mo.aluSrcA;
  assign bus.ALUSrcB    = mo.aluSrcB;
  assign bus.ResultSrc  = mo.resultSrc;
  assign bus.ALUControl = mo.aluOp ? cmdCtl : ALU_ADD;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences then random
// instructions, each cycle compared against an instruction-level model.
module tb_multicycle_controller;
  import arm_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   testCount = 0;
  int   failCount = 0;
  logic [3:0] modelFlags;

  multicycle_controller_if bus ();

  multicycle_controller #(.FLAG_RST(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    stateT      st;
    logic       irW, pcW, regW, memW, adr, srcA;
    logic [1:0] srcB, res, aluCtl, imm, regSrc;
  } expT;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ARM condition: pairs of codes share a base test, odd codes invert it.
  function automatic bit condPass(logic [3:0] cond, logic [3:0] f);
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    if (cond == 4'hF) return 1'b0;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return (cond[0] && cond != 4'hE) ? !r : r;
  endfunction

  function automatic int instrLen(logic [1:0] op, logic [5:0] f);
    case (op)
      2'b00:   return 4;
      2'b01:   return f[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] aluModel(logic [3:0] cmd);
    case (cmd)
      4'd4:    return 2'd0;
      4'd2:    return 2'd1;
      4'd0:    return 2'd2;
      4'd12:   return 2'd3;
      4'd10:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic expT phaseModel(int k, logic [1:0] op, logic [5:0] f, logic [3:0] rd, bit pass);
    expT e;
    bit writesReg;
    e = '0;
    writesReg = (f[4:1] inside {4'd4, 4'd2, 4'd0, 4'd12});
    e.imm    = op;
    e.regSrc = {op == 2'b01, op == 2'b10};
    if (k == 0) begin
      e.st = FETCH; e.irW = 1; e.pcW = 1; e.srcA = 1; e.srcB = 2; e.res = 2;
    end else if (k == 1) begin
      e.st = DECODE; e.srcA = 1; e.srcB = 2; e.res = 2;
    end else if (op == 2'b00) begin
      if (k == 2) begin
        e.st = f[5] ? EXECUTEI : EXECUTER;
        e.srcB = f[5] ? 2'd1 : 2'd0;
        e.aluCtl = aluModel(f[4:1]);
      end else begin
        e.st = ALUWB; e.res = 0;
        e.regW = pass && writesReg;
        e.pcW  = pass && (rd == 4'd15);
      end
    end else if (op == 2'b01) begin
      if (k == 2) begin
        e.st = MEMADR; e.srcB = 1;
      end else if (f[0] && k == 3) begin
        e.st = MEMREAD; e.adr = 1;
      end else if (f[0]) begin
        e.st = MEMWB; e.res = 1; e.regW = pass; e.pcW = pass && (rd == 4'd15);
      end else begin
        e.st = MEMWRITE; e.adr = 1; e.memW = pass;
      end
    end else begin
      e.st = BRANCH; e.srcB = 1; e.res = 2; e.pcW = pass;
    end
    return e;
  endfunction

  task automatic checkPhase(input string t, input expT e);
    check({t, ".state"},   32'(dut.state),      32'(e.st));
    check({t, ".IRWrite"}, 32'(bus.IRWrite),    32'(e.irW));
    check({t, ".PCWrite"}, 32'(bus.PCWrite),    32'(e.pcW));
    check({t, ".RegWrite"},32'(bus.RegWrite),   32'(e.regW));
    check({t, ".MemWrite"},32'(bus.MemWrite),   32'(e.memW));
    check({t, ".AdrSrc"},  32'(bus.AdrSrc),     32'(e.adr));
    check({t, ".ALUSrcA"}, 32'(bus.ALUSrcA),    32'(e.srcA));
    check({t, ".ALUSrcB"}, 32'(bus.ALUSrcB),    32'(e.srcB));
    check({t, ".ResultSrc"},32'(bus.ResultSrc), 32'(e.res));
    check({t, ".ALUCtl"},  32'(bus.ALUControl), 32'(e.aluCtl));
    check({t, ".ImmSrc"},  32'(bus.ImmSrc),     32'(e.imm));
    check({t, ".RegSrc"},  32'(bus.RegSrc),     32'(e.regSrc));
  endtask

  // Entered just after a rising edge with the DUT in FETCH; abortAt >= 0
  // raises reset in that phase instead of completing the instruction.
  task automatic runInstr(input string name, input logic [3:0] cond, input logic [1:0] op,
                          input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af,
                          input int abortAt);
    bit pass;
    int len;
    bit known, arith;
    bus.Cond = cond; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
    pass = condPass(cond, modelFlags);
    len  = instrLen(op, f);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      checkPhase($sformatf("%s.c%0d", name, k), phaseModel(k, op, f, rd, pass));
      if (k == abortAt) begin
        reset = 1'b1;
        #1;
        check({name, ".rst.MemWrite"}, 32'(bus.MemWrite), 32'd0);
        check({name, ".rst.PCWrite"},  32'(bus.PCWrite),  32'd0);
        check({name, ".rst.IRWrite"},  32'(bus.IRWrite),  32'd0);
        check({name, ".rst.RegWrite"}, 32'(bus.RegWrite), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelFlags = 4'b0000;
        check({name, ".rst.state"}, 32'(dut.state), 32'(FETCH));
        check({name, ".rst.flags"}, 32'(dut.uCondLogic.flags), 32'(modelFlags));
        return;
      end
      @(posedge clk);
      #1;
    end
    known = (f[4:1] inside {4'd4, 4'd2, 4'd0, 4'd12, 4'd10});
    arith = (f[4:1] inside {4'd4, 4'd2, 4'd10});
    if (op == 2'b00 && pass && f[0] && known) modelFlags[3:2] = af[3:2];
    if (op == 2'b00 && pass && f[0] && arith) modelFlags[1:0] = af[1:0];
    check({name, ".flags"}, 32'(dut.uCondLogic.flags), 32'(modelFlags));
  endtask

  initial begin
    logic [5:0] f;
    logic [1:0] op;
    logic [3:0] cond;
    logic [3:0] cmds [6];
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10, 4'd7};
    modelFlags = 4'b0000;
    reset = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd3; bus.ALUFlags = 4'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d.IRWrite", i),  32'(bus.IRWrite),  32'd0);
      check($sformatf("reset%0d.PCWrite", i),  32'(bus.PCWrite),  32'd0);
      check($sformatf("reset%0d.RegWrite", i), 32'(bus.RegWrite), 32'd0);
      check($sformatf("reset%0d.MemWrite", i), 32'(bus.MemWrite), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset.flags", 32'(dut.uCondLogic.flags), 32'd0);

    runInstr("ADD",   4'hE, 2'b00, 6'b001000, 4'd3, 4'h0, -1);
    runInstr("SUBS1", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, -1);
    runInstr("BEQ1",  4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, -1);
    runInstr("SUBS2", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, -1);
    runInstr("BEQ2",  4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, -1);
    runInstr("LDR",   4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, -1);
    runInstr("STR",   4'hE, 2'b01, 6'b011000, 4'd2, 4'h0, -1);
    runInstr("CMP",   4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110, -1);
    runInstr("STRNE", 4'h1, 2'b01, 6'b011000, 4'd2, 4'h0, -1);
    runInstr("UNDEF", 4'hE, 2'b11, 6'b000000, 4'd15, 4'h0, -1);

    for (int i = 0; i < 250; i++) begin
      op   = 2'($urandom_range(0, 3));
      cond = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      if (op == 2'b00)
        f = {1'($urandom_range(0, 1)), cmds[$urandom_range(0, 5)], 1'($urandom_range(0, 1))};
      else
        f = 6'($urandom_range(0, 63));
      runInstr($sformatf("rnd%0d", i), cond, op, f, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), -1);
    end

    runInstr("CMPALL", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b1111, -1);
    runInstr("STRRST", 4'hE, 2'b01, 6'b011000, 4'd2, 4'h0, 3);
    runInstr("ADD2",   4'hE, 2'b00, 6'b101001, 4'd4, 4'b1010, -1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM core. It sequences one shared ALU/memory/register-file datapath over 3–5 cycles per instruction.
- Decodes the instruction held in the datapath's instruction register and drives all datapath enables and muxes from a Moore main FSM.
- Owns the NZCV flag register and condition evaluation.
- Replaces the single-cycle decoder in the multicycle top.

Parameters:
FLAG_RST, 4'b0000, reset value of the NZCV flag register

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Cond  in  4  instruction bits [31:28] from the instruction register
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]
Rd  in  4  instruction bits [15:12]
ALUFlags  in  4  NZCV produced by the ALU in the current cycle
IRWrite  out  1  load instruction register
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
PCWrite  out  1  PC load enable
ALUSrcA  out  1  0=RD1 reg, 1=PC
ALUSrcB  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4
ResultSrc  out  2  00=ALUOut, 01=Data reg, 10=ALUResult
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  equals Op
RegSrc  out  2  bit0=(Op==10), bit1=(Op==01)

Behaviour:
- Reset (synchronous):
  - State goes to FETCH, Flags go to FLAG_RST, CondExR goes to 0.
  - While reset is high, IRWrite, MemWrite, RegWrite and PCWrite are forced to 0 combinationally. This holds even if reset rises mid-instruction; the next cycle after release is FETCH.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by Op: 00 → EXECUTEI if Funct[5], else EXECUTER. 01 → MEMADR. 10 → BRANCH. 11 → FETCH (unsupported; no writes).
  - MEMADR → MEMREAD if Funct[0] (load), else MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECUTER and EXECUTEI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Latency: branch 3 cycles, store 4, data-processing 4, load 5.
- Per-state Moore outputs (unlisted signals are 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 → ALUControl=00.
  - ALUOp=1, by Funct[4:1]: 0100 → 00; 0010 → 01; 0000 → 10; 1100 → 11; 1010 (CMP) → 01 with NoWrite=1.
  - Any other Funct[4:1] → ALUControl=00, RegW suppressed, no flag write.
- FlagW (active in EXECUTER/EXECUTEI only):
  - FlagW[1] (N,Z) = Funct[0].
  - FlagW[0] (C,V) = Funct[0] & (ADD | SUB | CMP).
- Condition:
  - CondEx is evaluated combinationally in DECODE from Cond and the registered Flags, using the standard ARM table. 1110 → 1; 1111 → 0 (reserved).
  - CondEx is captured into CondExR at the end of DECODE. All later gating uses CondExR, so a flag update in EXECUTE cannot alter the same instruction.
- Flags: N,Z load ALUFlags[3:2] when FlagW[1] & CondExR; C,V load ALUFlags[1:0] when FlagW[0] & CondExR. Capture is at the end of the EXECUTE cycle.
- Output gating:
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & CondExR).
  - RegWrite = RegW & ~NoWrite & CondExR.
  - MemWrite = MemW & CondExR.
- A failed condition still walks the full state sequence with no architectural writes.
- ImmSrc and RegSrc are combinational from Op and valid in every state.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state encoding (4-bit enum);
  - ALUControl codes;
  - ALUSrcB and ResultSrc select codes;
  - ARM condition-code constants.
- Sub-module cond_logic holds the Flags register, CondEx evaluation, CondExR and the write-enable gating.
- The FSM and ALU decode stay in the top module.

Test Plan:
- Hold reset 3 cycles:
  - all write enables are 0 throughout;
  - first cycle after release shows IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10.
- ADD R-type (Cond=1110, Op=00, Funct=001000, Rd=3):
  - visits FETCH, DECODE, EXECUTER, ALUWB;
  - ALUControl=00 in EXECUTER;
  - RegWrite=1 only in ALUWB, PCWrite=0 there.
- SUBS (Funct=000101, ALUFlags=0100) then BEQ (Cond=0000, Op=10):
  - BRANCH cycle shows PCWrite=1;
  - repeating with ALUFlags=0000 gives PCWrite=0 in BRANCH.
- Load and store:
  - LDR (Op=01, Funct=011001) takes 5 cycles, with AdrSrc=1 in MEMREAD and RegWrite=1 in MEMWB;
  - STR (Funct=011000) takes 4 cycles, with MemWrite=1 only in MEMWRITE.
- CMP (Funct=010101, ALUFlags=0110):
  - ALUControl=01;
  - RegWrite=0 in ALUWB;
  - Flags become 0110.
  - A following STR with Cond=0001 (NE) keeps MemWrite=0.
- Reset asserted during MEMWRITE:
  - MemWrite drops to 0 in that cycle;
  - state is FETCH after the edge;
  - Flags become 0000.
